// File: rtl/velocity_control_pi_clamp_pkg.sv
// Shared definitions for the velocity-loop PI regulator: default widths,
// FSM state type and a wide signed saturation helper.
package velocity_control_pi_clamp_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_GAIN_W    = 18;
  localparam int DEF_GAIN_FRAC = 12;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    SUM
  } state_t;

  // Clamp a signed value (sign-extended to 64 bits) into [lo, hi].
  function automatic logic signed [63:0] sat_range(input logic signed [63:0] x,
                                                   input logic signed [63:0] lo,
                                                   input logic signed [63:0] hi);
    logic signed [63:0] r;
    r = x;
    if (x > hi)
      r = hi;
    else if (x < lo)
      r = lo;
    return r;
  endfunction

endpackage

// File: rtl/velocity_control_pi_clamp_if.sv
// Sample strobe, controller reset, operands and results of the PI regulator.
interface velocity_control_pi_clamp_if #(
  parameter int DATA_W = 32,
  parameter int GAIN_W = 18
) ();

  logic                     enb_1_2000_0;
  logic                     Reset_1;
  logic signed [DATA_W-1:0] In;
  logic signed [GAIN_W-1:0] Kp;
  logic signed [GAIN_W-1:0] Ki;
  logic signed [DATA_W-1:0] Out;
  logic                     out_valid;
  logic                     sat;
  logic                     overrun;

  modport master (
    output enb_1_2000_0, Reset_1, In, Kp, Ki,
    input  Out, out_valid, sat, overrun
  );

  modport slave (
    input  enb_1_2000_0, Reset_1, In, Kp, Ki,
    output Out, out_valid, sat, overrun
  );

endinterface

// File: rtl/velocity_control_pi_clamp_sat.sv
// Parameterised signed clamp: dout = din limited to [lo, hi], hit when limited.
module velocity_control_pi_clamp_sat
  import velocity_control_pi_clamp_pkg::*;
#(
  parameter int IN_W  = 50,
  parameter int OUT_W = 32
) (
  input  logic signed [IN_W-1:0]  din,
  input  logic signed [OUT_W-1:0] lo,
  input  logic signed [OUT_W-1:0] hi,
  output logic signed [OUT_W-1:0] dout,
  output logic                    hit
);

  logic signed [63:0] wide;

  // Clamp in a common wide domain, then narrow to the output width.
  always_comb begin
    wide = sat_range(64'(din), 64'(lo), 64'(hi));
    dout = wide[OUT_W-1:0];
    hit  = (wide != 64'(din));
  end

endmodule

// File: rtl/velocity_control_pi_clamp.sv
// Discrete PI regulator with clamp-type anti-windup, one sample per strobe.
// Pipeline: strobe edge registers operands, MUL registers scaled products,
// SUM updates integrator and the saturated command.
module velocity_control_pi_clamp
  import velocity_control_pi_clamp_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int GAIN_W    = DEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}},
  parameter logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}}
) (
  input logic                   CLK_IN,
  input logic                   reset,
  velocity_control_pi_clamp_if.slave bus
);

  localparam int PW    = DATA_W + GAIN_W;
  localparam int ACC_W = DATA_W + 2;
  localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] in_r, p_r, k_r, integ_r, out_r;
  logic signed [GAIN_W-1:0] kp_r, ki_r;
  logic                     valid_r, sat_r, overrun_r;

  logic signed [PW-1:0]     p_full, k_full;
  logic signed [DATA_W-1:0] p_next, k_next, i_new, out_next;
  logic signed [ACC_W-1:0]  acc_i, u;
  logic                     out_hit, hold, accept, clear;
  logic                     p_hit_unused, k_hit_unused, i_hit_unused;

  assign clear  = reset | bus.Reset_1;
  assign accept = (state_q == IDLE) & bus.enb_1_2000_0 & ~bus.Reset_1;

  // State register; either reset aborts any in-flight sample.
  always_ff @(posedge CLK_IN) begin
    if (clear)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic: one strobe walks IDLE -> MUL -> SUM -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enb_1_2000_0) state_d = MUL;
      MUL:     state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-width products with floor scaling, then saturation to DATA_W.
  always_comb begin
    p_full = (PW'(kp_r) * PW'(in_r)) >>> GAIN_FRAC;
    k_full = (PW'(ki_r) * PW'(in_r)) >>> GAIN_FRAC;
  end

  velocity_control_pi_clamp_sat #(.IN_W(PW), .OUT_W(DATA_W)) u_sat_p (
    .din(p_full), .lo(DATA_MIN), .hi(DATA_MAX), .dout(p_next), .hit(p_hit_unused)
  );

  velocity_control_pi_clamp_sat #(.IN_W(PW), .OUT_W(DATA_W)) u_sat_k (
    .din(k_full), .lo(DATA_MIN), .hi(DATA_MAX), .dout(k_next), .hit(k_hit_unused)
  );

  // Integrator candidate and controller sum in guard-bit precision.
  always_comb begin
    acc_i = ACC_W'(integ_r) + ACC_W'(k_r);
    u     = ACC_W'(p_r) + ACC_W'(i_new);
    hold  = ((u > ACC_W'(OUT_MAX)) & ~k_r[DATA_W-1] & (k_r != '0)) |
            ((u < ACC_W'(OUT_MIN)) &  k_r[DATA_W-1]);
  end

  velocity_control_pi_clamp_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_i (
    .din(acc_i), .lo(OUT_MIN), .hi(OUT_MAX), .dout(i_new), .hit(i_hit_unused)
  );

  velocity_control_pi_clamp_sat #(.IN_W(ACC_W), .OUT_W(DATA_W)) u_sat_out (
    .din(u), .lo(OUT_MIN), .hi(OUT_MAX), .dout(out_next), .hit(out_hit)
  );

  // Datapath registers, integrator, status flags.
  always_ff @(posedge CLK_IN) begin
    if (clear) begin
      in_r      <= '0;
      kp_r      <= '0;
      ki_r      <= '0;
      p_r       <= '0;
      k_r       <= '0;
      integ_r   <= '0;
      out_r     <= '0;
      valid_r   <= 1'b0;
      sat_r     <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      if (accept) begin
        in_r <= bus.In;
        kp_r <= bus.Kp;
        ki_r <= bus.Ki;
      end
      if (bus.enb_1_2000_0 && state_q != IDLE)
        overrun_r <= 1'b1;
      if (state_q == MUL) begin
        p_r <= p_next;
        k_r <= k_next;
      end
      if (state_q == SUM) begin
        out_r   <= out_next;
        sat_r   <= out_hit;
        valid_r <= 1'b1;
        if (!hold)
          integ_r <= i_new;
      end
    end
  end

  assign bus.Out       = bus.Reset_1 ? '0 : out_r;
  assign bus.out_valid = valid_r;
  assign bus.sat       = sat_r;
  assign bus.overrun   = overrun_r;

endmodule

// File: tb/tb_velocity_control_pi_clamp.sv
// Self-checking bench for the velocity-loop PI regulator.
module tb_velocity_control_pi_clamp;

  localparam longint D_MAX = 64'sd2147483647;
  localparam longint D_MIN = -64'sd2147483648;
  localparam longint O_MAX = 1000;
  localparam longint O_MIN = -1000;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;
  longint m_int = 0;

  velocity_control_pi_clamp_if #(.DATA_W(32), .GAIN_W(18)) bus ();

  velocity_control_pi_clamp #(
    .DATA_W(32), .GAIN_W(18), .GAIN_FRAC(12),
    .OUT_MAX(32'sd1000), .OUT_MIN(-32'sd1000)
  ) dut (
    .CLK_IN(clk),
    .reset(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit  clr;
    int  in_v;
    int  kp_v;
    int  ki_v;
    int  exp_out;
    bit  exp_sat;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clampl(input longint x, input longint lo, input longint hi);
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Reference: one PI step from the regulator's arithmetic rules.
  task automatic model(input longint in_v, input longint kp_v, input longint ki_v,
                       output longint o, output bit s);
    longint p, k, inew, u;
    p    = clampl((kp_v * in_v) >>> 12, D_MIN, D_MAX);
    k    = clampl((ki_v * in_v) >>> 12, D_MIN, D_MAX);
    inew = clampl(m_int + k, O_MIN, O_MAX);
    u    = p + inew;
    o    = clampl(u, O_MIN, O_MAX);
    s    = (u > O_MAX) || (u < O_MIN);
    if (!((u > O_MAX && k > 0) || (u < O_MIN && k < 0)))
      m_int = inew;
  endtask

  task automatic clear_ctrl();
    @(negedge clk);
    bus.Reset_1 = 1'b1;
    @(negedge clk);
    bus.Reset_1 = 1'b0;
    m_int = 0;
  endtask

  task automatic run_sample(input int i_v, input int k_p, input int k_i,
                            input longint exp_out, input bit exp_sat, input string tag);
    int cnt;
    bit seen;
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b1;
    bus.In = i_v;
    bus.Kp = k_p[17:0];
    bus.Ki = k_i[17:0];
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b0;
    cnt  = 0;
    seen = 1'b0;
    while (!seen && cnt < 8) begin
      @(negedge clk);
      cnt++;
      if (bus.out_valid) seen = 1'b1;
    end
    check({tag, " latency"}, cnt, 2);
    check({tag, " Out"}, bus.Out, exp_out);
    check({tag, " sat"}, bus.sat, exp_sat);
    @(negedge clk);
    check({tag, " valid pulse"}, bus.out_valid, 0);
    check({tag, " Out hold"}, bus.Out, exp_out);
  endtask

  initial begin
    int pulses;
    longint last_out;
    longint eo;
    bit es;
    int ri, rkp, rki;

    rst = 1'b1;
    bus.enb_1_2000_0 = 1'b0;
    bus.Reset_1 = 1'b0;
    bus.In = '0;
    bus.Kp = '0;
    bus.Ki = '0;

    tbl[0] = '{0,   100, 4096, 2048,   150, 0};
    tbl[1] = '{0,   100, 4096, 2048,   200, 0};
    tbl[2] = '{1,  2000, 4096, 2048,  1000, 1};
    tbl[3] = '{0,  -100, 4096, 2048,  -150, 0};
    tbl[4] = '{1,    -3,    0, 2048,    -2, 0};
    tbl[5] = '{0,    -3,    0, 2048,    -4, 0};
    tbl[6] = '{1, -2000, 4096, 2048, -1000, 1};
    tbl[7] = '{0,     0, 4096, 2048,     0, 0};

    repeat (3) @(negedge clk);
    check("reset Out", bus.Out, 0);
    check("reset out_valid", bus.out_valid, 0);
    check("reset sat", bus.sat, 0);
    check("reset overrun", bus.overrun, 0);
    rst = 1'b0;

    // Directed vectors: basic response, limits, floor rounding.
    for (int v = 0; v < 8; v++) begin
      if (tbl[v].clr) clear_ctrl();
      run_sample(tbl[v].in_v, tbl[v].kp_v, tbl[v].ki_v,
                 tbl[v].exp_out, tbl[v].exp_sat, $sformatf("vec%0d", v));
    end

    // Reset_1 one clock after a strobe aborts the sample.
    clear_ctrl();
    run_sample(100, 4096, 2048, 150, 0, "t4 pre");
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b1;
    bus.In = 100;
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b0;
    bus.Reset_1 = 1'b1;
    #1;
    check("t4 Out comb zero", bus.Out, 0);
    @(negedge clk);
    bus.Reset_1 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("t4 aborted pulses", pulses, 0);
    check("t4 Out cleared", bus.Out, 0);
    run_sample(100, 4096, 2048, 150, 0, "t4 post");

    // Back-to-back strobes: overrun sticky, only first sample used.
    clear_ctrl();
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b1;
    bus.In = 100;
    bus.Kp = 18'sd4096;
    bus.Ki = 18'sd2048;
    @(negedge clk);
    bus.In = 500;
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b0;
    pulses = 0;
    last_out = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        pulses++;
        last_out = bus.Out;
      end
    end
    check("t5 pulses", pulses, 1);
    check("t5 Out", last_out, 150);
    check("t5 overrun", bus.overrun, 1);
    run_sample(100, 4096, 2048, 200, 0, "t5 next");
    check("t5 overrun sticky", bus.overrun, 1);
    clear_ctrl();
    check("t5 overrun cleared", bus.overrun, 0);

    // Strobe coincident with Reset_1 is dropped.
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b1;
    bus.Reset_1 = 1'b1;
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b0;
    bus.Reset_1 = 1'b0;
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    check("drop pulses", pulses, 0);
    check("drop overrun", bus.overrun, 0);
    run_sample(100, 4096, 2048, 150, 0, "drop post");

    // reset during SUM with a non-zero integrator.
    clear_ctrl();
    run_sample(1000, 0, 2048, 500, 0, "t6 pre");
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b1;
    bus.In = 100;
    bus.Kp = 18'sd4096;
    @(negedge clk);
    bus.enb_1_2000_0 = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6 Out", bus.Out, 0);
    check("t6 out_valid", bus.out_valid, 0);
    check("t6 sat", bus.sat, 0);
    check("t6 overrun", bus.overrun, 0);
    rst = 1'b0;
    m_int = 0;
    run_sample(100, 4096, 2048, 150, 0, "t6 a");
    run_sample(100, 4096, 2048, 200, 0, "t6 b");

    // Randomised samples against the reference model.
    clear_ctrl();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 19) == 0) clear_ctrl();
      if ($urandom_range(0, 3) == 0)
        ri = int'($urandom);
      else
        ri = int'($urandom_range(0, 6000)) - 3000;
      if ($urandom_range(0, 4) == 0) begin
        rkp = int'($urandom_range(0, 262143)) - 131072;
        rki = int'($urandom_range(0, 262143)) - 131072;
      end else begin
        rkp = int'($urandom_range(0, 16384)) - 8192;
        rki = int'($urandom_range(0, 16384)) - 8192;
      end
      model(longint'(ri), longint'(rkp), longint'(rki), eo, es);
      run_sample(ri, rkp, rki, eo, es, $sformatf("rand%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
